// File: rtl/ex_mem_skid_if.sv
// Execute-to-memory stage bundle: instruction fields and ALU flags in, head-entry fields out.
// master = the environment (execute + memory stages), slave = the ex_mem_skid stage.
interface ex_mem_skid_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_zero;
    logic                  alu_overflow;
    logic                  trap_en;
    logic                  branch;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]     store_data;
    logic [DATA_W-1:0]     pc;
    logic                  flush;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_result;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic [DATA_W-1:0]     out_store_data;
    logic [DATA_W-1:0]     out_pc;
    logic                  out_reg_write;
    logic                  out_mem_read;
    logic                  out_mem_write;
    logic                  out_branch_taken;
    logic                  out_exc;
    logic                  exc_pending;
    logic [DATA_W-1:0]     exc_pc;

    modport master (
        output in_valid, alu_result, alu_zero, alu_overflow, trap_en, branch,
               reg_write, mem_read, mem_write, rd_addr, store_data, pc, flush,
               out_ready,
        input  in_ready, out_valid, out_result, out_rd_addr, out_store_data, out_pc,
               out_reg_write, out_mem_read, out_mem_write, out_branch_taken, out_exc,
               exc_pending, exc_pc
    );

    modport slave (
        input  in_valid, alu_result, alu_zero, alu_overflow, trap_en, branch,
               reg_write, mem_read, mem_write, rd_addr, store_data, pc, flush,
               out_ready,
        output in_ready, out_valid, out_result, out_rd_addr, out_store_data, out_pc,
               out_reg_write, out_mem_read, out_mem_write, out_branch_taken, out_exc,
               exc_pending, exc_pc
    );
endinterface

// File: rtl/ex_mem_skid.sv
// EX/MEM stage: 2-entry skid buffer capturing ALU results, resolving branches and trapping overflow.
// Latency: 1 cycle from accept to head when empty or draining; 1 instr/cycle with out_ready high.
// Backpressure: in_ready is registered from internal state (plus flush); EX_MEM_SKID_STATS_EN adds counters.
module ex_mem_skid #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
`ifdef EX_MEM_SKID_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] retired,
`endif
    ex_mem_skid_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0]     store_data;
        logic [DATA_W-1:0]     pc;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch_taken;
        logic                  exc;
    } entry_t;

    state_t            state_q;
    state_t            state_nxt;
    entry_t            head_q;
    entry_t            skid_q;
    entry_t            cap;
    logic              rdy_q;
    logic              exc_pending_q;
    logic              exc_pending_nxt;
    logic [DATA_W-1:0] exc_pc_q;

    logic              head_vld;
    logic              accept;
    logic              deq;
    logic              head_ld;
    logic              head_from_skid;
    logic              skid_ld;

    // Trap gating happens at capture so downstream never sees side effects of a trapping op.
    always_comb begin
        cap              = '0;
        cap.exc          = bus.alu_overflow && bus.trap_en;
        cap.result       = bus.alu_result;
        cap.rd_addr      = bus.rd_addr;
        cap.store_data   = bus.store_data;
        cap.pc           = bus.pc;
        cap.reg_write    = bus.reg_write && !cap.exc;
        cap.mem_read     = bus.mem_read  && !cap.exc;
        cap.mem_write    = bus.mem_write && !cap.exc;
        cap.branch_taken = bus.branch && bus.alu_zero && !cap.exc;
    end

    assign head_vld     = (state_q != EMPTY);
    assign bus.in_ready = rdy_q && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign deq          = head_vld && bus.out_ready;

    always_comb begin
        state_nxt      = state_q;
        head_ld        = 1'b0;
        head_from_skid = 1'b0;
        skid_ld        = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_ld   = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && deq) begin
                    head_ld = 1'b1;
                end else if (accept) begin
                    skid_ld   = 1'b1;
                    state_nxt = FULL;
                end else if (deq) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (deq) begin
                    head_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // accept is already blocked by flush, so only the state needs overriding.
        if (bus.flush) begin
            state_nxt      = EMPTY;
            head_from_skid = 1'b0;
        end
    end

    always_comb begin
        exc_pending_nxt = exc_pending_q;
        if (bus.flush) begin
            exc_pending_nxt = 1'b0;
        end else if (accept && cap.exc) begin
            exc_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            rdy_q         <= 1'b1;
            exc_pending_q <= 1'b0;
            exc_pc_q      <= '0;
        end else begin
            state_q       <= state_nxt;
            rdy_q         <= (state_nxt != FULL) && !exc_pending_nxt;
            exc_pending_q <= exc_pending_nxt;
            if (accept && cap.exc) begin
                exc_pc_q <= bus.pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (head_ld) begin
                head_q <= cap;
            end else if (head_from_skid) begin
                head_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= cap;
            end
        end
    end

    assign bus.out_valid        = head_vld;
    assign bus.out_result       = head_q.result;
    assign bus.out_rd_addr      = head_q.rd_addr;
    assign bus.out_store_data   = head_q.store_data;
    assign bus.out_pc           = head_q.pc;
    assign bus.out_reg_write    = head_q.reg_write;
    assign bus.out_mem_read     = head_q.mem_read;
    assign bus.out_mem_write    = head_q.mem_write;
    assign bus.out_branch_taken = head_q.branch_taken;
    assign bus.out_exc          = head_q.exc;
    assign bus.exc_pending      = exc_pending_q;
    assign bus.exc_pc           = exc_pc_q;

`ifdef EX_MEM_SKID_STATS_EN
    // Counters survive flush so they reflect the whole run since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            retired      <= '0;
        end else begin
            if (head_vld && !bus.out_ready) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (deq) begin
                retired <= retired + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: scenario tasks with inline checks plus a scoreboard of accepted instructions.
module tb_ex_mem_skid;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_mem_skid_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

`ifdef EX_MEM_SKID_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] retired;
`endif

    ex_mem_skid #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef EX_MEM_SKID_STATS_EN
        .stall_cycles (stall_cycles),
        .retired      (retired),
`endif
        .bus          (bus)
    );

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic [31:0] sd;
        logic [31:0] pc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        bt;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_exp;
    exp_t sb_obs;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model();
        exp_t e;
        e.exc    = bus.alu_overflow & bus.trap_en;
        e.result = bus.alu_result;
        e.rd     = bus.rd_addr;
        e.sd     = bus.store_data;
        e.pc     = bus.pc;
        e.rw     = bus.reg_write & ~e.exc;
        e.mr     = bus.mem_read  & ~e.exc;
        e.mw     = bus.mem_write & ~e.exc;
        e.bt     = bus.branch & bus.alu_zero & ~e.exc;
        return e;
    endfunction

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.alu_result   = '0;
        bus.alu_zero     = 1'b0;
        bus.alu_overflow = 1'b0;
        bus.trap_en      = 1'b0;
        bus.branch       = 1'b0;
        bus.reg_write    = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.rd_addr      = '0;
        bus.store_data   = '0;
        bus.pc           = '0;
    endtask

    task automatic present(input logic [31:0] res, input logic zero, input logic ovf,
                           input logic trap, input logic br, input logic rw,
                           input logic mr, input logic mw, input logic [4:0] rd,
                           input logic [31:0] sd, input logic [31:0] pc);
        bus.in_valid     = 1'b1;
        bus.alu_result   = res;
        bus.alu_zero     = zero;
        bus.alu_overflow = ovf;
        bus.trap_en      = trap;
        bus.branch       = br;
        bus.reg_write    = rw;
        bus.mem_read     = mr;
        bus.mem_write    = mw;
        bus.rd_addr      = rd;
        bus.store_data   = sd;
        bus.pc           = pc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, pop and compare on dequeue, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                sb_obs = {bus.out_result, bus.out_rd_addr, bus.out_store_data, bus.out_pc,
                          bus.out_reg_write, bus.out_mem_read, bus.out_mem_write,
                          bus.out_branch_taken, bus.out_exc};
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: dequeued result=%h with nothing expected", bus.out_result);
                end else begin
                    sb_exp = sb_q.pop_front();
                    if (sb_obs !== sb_exp) begin
                        errors++;
                        $display("FAIL sb_entry: got %h want %h", sb_obs, sb_exp);
                    end
                end
            end
            if (bus.flush) sb_q.delete();
            else if (bus.in_valid && bus.in_ready) sb_q.push_back(model());
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.exc_pending !== 1'b0 || bus.exc_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_exc: exc_pending=%b exc_pc=%h want 0 0", bus.exc_pending, bus.exc_pc);
        end
        checks++;
        if ({bus.out_result, bus.out_pc, bus.out_store_data, bus.out_rd_addr, bus.out_reg_write,
             bus.out_mem_read, bus.out_mem_write, bus.out_branch_taken, bus.out_exc} !== '0) begin
            errors++;
            $display("FAIL reset_data: result=%h pc=%h sd=%h rd=%h want all 0",
                     bus.out_result, bus.out_pc, bus.out_store_data, bus.out_rd_addr);
        end
`ifdef EX_MEM_SKID_STATS_EN
        checks++;
        if (stall_cycles !== 32'd0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: stall=%0d retired=%0d want 0 0", stall_cycles, retired);
        end
`endif
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            next_cycle();
            if (k < 4) present(32'h10 * (k + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               5'(k + 1), 32'hA0 + k, 32'h0040_0000 + 4 * k);
            else idle();
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_in_ready[%0d]: got %b want 1", k, bus.in_ready);
                end
            end
            if (k > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h10 * k) begin
                    errors++;
                    $display("FAIL stream_latency[%0d]: valid=%b result=%h want 1 %h",
                             k, bus.out_valid, bus.out_result, 32'h10 * k);
                end
            end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drained: out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        next_cycle();
        bus.out_ready = 1'b0;
        present(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 32'h1, 32'h100);
        next_cycle();
        present(32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h2, 32'h104);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_accept: in_ready=%b want 1", bus.in_ready);
        end
        next_cycle();
        present(32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h3, 32'h108);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'h10) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b valid=%b result=%h want 0 1 10",
                     bus.in_ready, bus.out_valid, bus.out_result);
        end
        next_cycle();
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_registered: in_ready=%b want 0", bus.in_ready);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_result !== 32'h20) begin
            errors++;
            $display("FAIL bp_drain: in_ready=%b result=%h want 1 20", bus.in_ready, bus.out_result);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h30) begin
            errors++;
            $display("FAIL bp_third: valid=%b result=%h want 1 30", bus.out_valid, bus.out_result);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_trap();
        next_cycle();
        bus.out_ready = 1'b1;
        present(32'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 32'h0040_0020);
        next_cycle();
        present(32'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0, 32'h0040_0024);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_exc !== 1'b1 || bus.out_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL trap_head: valid=%b exc=%b reg_write=%b want 1 1 0",
                     bus.out_valid, bus.out_exc, bus.out_reg_write);
        end
        checks++;
        if (bus.exc_pending !== 1'b1 || bus.exc_pc !== 32'h0040_0020 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL trap_sticky: pending=%b exc_pc=%h in_ready=%b want 1 00400020 0",
                     bus.exc_pending, bus.exc_pc, bus.in_ready);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL trap_blocks: valid=%b in_ready=%b want 0 0", bus.out_valid, bus.in_ready);
        end
        next_cycle();
        idle();
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.exc_pending !== 1'b0 || bus.exc_pc !== 32'h0040_0020 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL trap_flush: pending=%b exc_pc=%h in_ready=%b want 0 00400020 1",
                     bus.exc_pending, bus.exc_pc, bus.in_ready);
        end
        next_cycle();
        present(32'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0, 32'h0040_0024);
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_exc !== 1'b0 || bus.out_reg_write !== 1'b1 ||
            bus.exc_pending !== 1'b0) begin
            errors++;
            $display("FAIL untrapped_ovf: valid=%b exc=%b reg_write=%b pending=%b want 1 0 1 0",
                     bus.out_valid, bus.out_exc, bus.out_reg_write, bus.exc_pending);
        end
        next_cycle();
    endtask

    task automatic test_branch();
        next_cycle();
        bus.out_ready = 1'b1;
        present(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h200);
        next_cycle();
        present(32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h204);
        @(negedge clk);
        checks++;
        if (bus.out_branch_taken !== 1'b1) begin
            errors++;
            $display("FAIL branch_taken: got %b want 1", bus.out_branch_taken);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL branch_not_taken: valid=%b taken=%b want 1 0", bus.out_valid, bus.out_branch_taken);
        end
        next_cycle();
    endtask

    task automatic test_flush_full();
        next_cycle();
        bus.out_ready = 1'b0;
        present(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 32'h0, 32'h300);
        next_cycle();
        present(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h9, 32'h304);
        next_cycle();
        present(32'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0, 32'h308);
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 0", bus.in_ready);
        end
        next_cycle();
        bus.flush = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.exc_pending !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: valid=%b pending=%b in_ready=%b want 0 0 1",
                     bus.out_valid, bus.exc_pending, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_resurrect[%0d]: valid=%b result=%h want 0",
                         k, bus.out_valid, bus.out_result);
            end
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        bus.out_ready = 1'b0;
        present(32'h900, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0, 32'h400);
        next_cycle();
        present(32'h910, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 32'h0, 32'h404);
        test_reset();
    endtask

`ifdef EX_MEM_SKID_STATS_EN
    task automatic test_stats();
        test_reset();
        next_cycle();
        bus.out_ready = 1'b0;
        present(32'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 32'h0, 32'h500);
        next_cycle();
        idle();
        repeat (4) next_cycle();
        next_cycle();
        bus.out_ready = 1'b1;
        present(32'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0, 32'h504);
        next_cycle();
        present(32'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 32'h508);
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (stall_cycles !== 32'd5 || retired !== 32'd3) begin
            errors++;
            $display("FAIL stats: stall=%0d retired=%0d want 5 3", stall_cycles, retired);
        end
    endtask
`endif

    initial begin
        idle();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_trap();
        test_branch();
        test_flush_full();
        test_reset_mid();
`ifdef EX_MEM_SKID_STATS_EN
        test_stats();
`endif
        next_cycle();
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries never dequeued, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Pipeline stage directly downstream of the ALU in the mini-MIPS execute path.
- Captures ALU outputs (result, zero, overflow) together with the instruction's control and address fields.
- Holds them in a 2-entry skid buffer so the memory stage can stall without creating a combinational ready path back into execute.
- Resolves branch-taken and detects trapping arithmetic overflow.

Parameters:
- DATA_W, 32, width of result, store data and PC.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept; registered, depends only on internal state.
- alu_result  in  DATA_W  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU signed-overflow flag.
- trap_en  in  1  instruction traps on overflow (add/sub); 0 for unsigned forms.
- branch  in  1  instruction is a conditional branch on zero.
- reg_write  in  1  writeback enable.
- mem_read  in  1  load.
- mem_write  in  1  store.
- rd_addr  in  REG_ADDR_W  destination register.
- store_data  in  DATA_W  store data.
- pc  in  DATA_W  instruction PC.
- flush  in  1  discard all buffered and incoming instructions.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage accepts head.
- out_result, out_rd_addr, out_store_data, out_pc  out  as inputs  head-entry fields.
- out_reg_write, out_mem_read, out_mem_write  out  1  head-entry control; already gated by trap.
- out_branch_taken  out  1  branch && zero of head entry.
- out_exc  out  1  head entry is a trapping overflow.
- exc_pending  out  1  sticky: a trapping overflow has been accepted.
- exc_pc  out  DATA_W  PC of the trapping instruction.

Behaviour:
- Reset: state EMPTY, out_valid=0, in_ready=1, exc_pending=0, exc_pc=0. All out_* data fields are 0.
- Storage: head register (drives out_*) and skid register.
  - States: EMPTY (none), ONE (head only), FULL (head+skid).
- Handshakes:
  - Accept = in_valid && in_ready.
  - Dequeue = out_valid && out_ready.
  - in_ready = (state != FULL) && !exc_pending && !flush.
- Transitions:
  - EMPTY: accept -> head<=in, ONE.
  - ONE:
    - accept && dequeue -> head<=in, stay ONE.
    - accept only -> skid<=in, FULL.
    - dequeue only -> EMPTY.
  - FULL:
    - dequeue -> head<=skid, ONE. No accept is possible.
- Latency: input accepted in cycle N appears on out_* in N+1 if the buffer was empty or the head dequeues in N. Full throughput is 1/cycle with out_ready held high.
- Capture-time computation:
  - exc = alu_overflow && trap_en.
  - When exc=1, stored reg_write, mem_read and mem_write are forced 0.
  - branch_taken = branch && alu_zero && !exc.
- Trap:
  - On accepting an exc instruction, exc_pending<=1 and exc_pc<=pc.
  - While exc_pending=1, no further instructions are accepted.
  - Already-buffered older entries still drain normally.
  - exc_pending and exc_pc hold until flush or rst.
- Flush (synchronous, priority over accept/dequeue):
  - Next state EMPTY, out_valid=0, exc_pending=0. exc_pc is retained.
  - An input presented in the flush cycle is dropped.
  - A dequeue in the flush cycle is still considered consumed by downstream.
- rst has priority over flush. Reset mid-stream discards all entries.
- Data fields of an invalid head are don't-care except after reset, when they are 0.
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro EX_MEM_SKID_STATS_EN.
- When defined:
  - Add outputs stall_cycles[31:0] and retired[31:0].
  - stall_cycles increments each cycle out_valid && !out_ready.
  - retired increments on each dequeue.
  - Both wrap at 2^32, clear on rst only (not flush).
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then stream 4 instructions (alu_result 0x10,0x20,0x30,0x40) with out_ready=1 -> outputs in order, each 1 cycle after accept; in_ready stays 1.
- out_ready=0, present 3 valid instructions -> first two accepted (state FULL), in_ready=0 on the third. Raise out_ready -> 0x10 then 0x20, then third accepted; no loss or duplication.
- Instruction with alu_overflow=1, trap_en=1, pc=0x00400020, reg_write=1 -> out_exc=1, out_reg_write=0, exc_pending=1, exc_pc=0x00400020, in_ready=0. Same with trap_en=0 -> normal writeback, no exc.
- branch=1, alu_zero=1 -> out_branch_taken=1; alu_zero=0 -> 0.
- State FULL, assert flush with in_valid=1 -> next cycle out_valid=0, exc_pending=0, flushed input never appears on outputs.
- With EX_MEM_SKID_STATS_EN: hold out_ready=0 for 5 cycles with one entry, then dequeue 3 entries -> stall_cycles=5, retired=3.
